// File: rtl/counter_mon_pkg.sv
// Shared types and helpers for the counter monitor.
// Contents:
//   mon_state_e    - monitor lock state
//   next_expected  - value the counter must show next, given last value/enable
package counter_mon_pkg;

  localparam int unsigned MON_VAL_MAX_W = 32;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCKED   = 2'd1,
    FAULT    = 2'd2
  } mon_state_e;

  // Caller truncates the result to its own width, which gives the modulo wrap.
  function automatic logic [MON_VAL_MAX_W-1:0] next_expected(
    input logic [MON_VAL_MAX_W-1:0] val,
    input logic                     en
  );
    return en ? (val + MON_VAL_MAX_W'(1)) : val;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports:
//   clk, rst_n  - clock, synchronous active-low reset
//   clr_i       - clear to zero (wins over inc_i)
//   inc_i       - increment by one, holds at all-ones
//   count_o     - registered count
module sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: clear, saturating increment, or hold.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && !(&count_q)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/counter_monitor.sv
// Passive checker for a counter interface: verifies that cnt_val follows
// the enable-driven counting rule and reports wraps, mismatches, lock status
// and saturating statistics. All outputs are registered.
// Optional feature macro: COUNTER_MON_ERRLOG_EN adds err_exp_log/err_obs_log,
// the expected/observed values of the first mismatch since reset/stat_clr.
// Ports:
//   clk, rst_n            - clock, synchronous active-low reset
//   cnt_en, cnt_val       - monitored counter enable and value
//   stat_clr              - clear statistics/sticky flag, return to UNLOCKED
//   locked                - state is LOCKED
//   wrap_pulse, err_pulse - one-cycle event pulses
//   err_sticky            - any mismatch since reset/stat_clr
//   wrap_cnt, err_cnt     - saturating event counts
module counter_monitor
  import counter_mon_pkg::*;
#(
  parameter int unsigned BIT_WIDTH     = 5,
  parameter int unsigned STAT_WIDTH    = 8,
  parameter int unsigned RELOCK_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cnt_en,
  input  logic [BIT_WIDTH-1:0]  cnt_val,
  input  logic                  stat_clr,
  output logic                  locked,
  output logic                  wrap_pulse,
  output logic                  err_pulse,
  output logic                  err_sticky,
  output logic [STAT_WIDTH-1:0] wrap_cnt,
  output logic [STAT_WIDTH-1:0] err_cnt
`ifdef COUNTER_MON_ERRLOG_EN
  ,
  output logic [BIT_WIDTH-1:0]  err_exp_log,
  output logic [BIT_WIDTH-1:0]  err_obs_log
`endif
);

  localparam int unsigned RUN_W = $clog2(RELOCK_CYCLES + 1);

  mon_state_e           state_q, state_d;
  logic [RUN_W-1:0]     run_q, run_d;
  logic [BIT_WIDTH-1:0] prev_val_q;
  logic                 prev_en_q;
  logic                 wrap_pulse_q, err_pulse_q, err_sticky_q;
  logic [BIT_WIDTH-1:0] expected;
  logic [RUN_W-1:0]     run_inc;
  logic                 cmp_en;
  logic                 mismatch;
  logic                 wrap;

  // Compare against the value implied by last cycle's sample.
  always_comb begin
    expected = BIT_WIDTH'(next_expected(MON_VAL_MAX_W'(prev_val_q), prev_en_q));
    cmp_en   = (state_q != UNLOCKED);
    mismatch = cmp_en && (cnt_val != expected);
    wrap     = cmp_en && !mismatch && prev_en_q && (&prev_val_q);
    run_inc  = run_q + RUN_W'(1);
  end

  // Lock state and relock run length.
  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    case (state_q)
      UNLOCKED: begin
        state_d = LOCKED;
        run_d   = '0;
      end
      LOCKED: begin
        if (mismatch) begin
          state_d = FAULT;
          run_d   = '0;
        end
      end
      FAULT: begin
        if (mismatch) begin
          run_d = '0;
        end else if (run_inc == RUN_W'(RELOCK_CYCLES)) begin
          state_d = LOCKED;
          run_d   = '0;
        end else begin
          run_d = run_inc;
        end
      end
      default: begin
        state_d = UNLOCKED;
        run_d   = '0;
      end
    endcase
    if (stat_clr) begin
      state_d = UNLOCKED;
      run_d   = '0;
    end
  end

  // History is captured even on stat_clr so the monitor relocks one cycle later.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= UNLOCKED;
      run_q        <= '0;
      prev_val_q   <= '0;
      prev_en_q    <= 1'b0;
      wrap_pulse_q <= 1'b0;
      err_pulse_q  <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      run_q        <= run_d;
      prev_val_q   <= cnt_val;
      prev_en_q    <= cnt_en;
      wrap_pulse_q <= wrap && !stat_clr;
      err_pulse_q  <= mismatch && !stat_clr;
      err_sticky_q <= !stat_clr && (err_sticky_q || mismatch);
    end
  end

  sat_counter #(.WIDTH(STAT_WIDTH)) u_wrap_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (stat_clr),
    .inc_i   (wrap),
    .count_o (wrap_cnt)
  );

  sat_counter #(.WIDTH(STAT_WIDTH)) u_err_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (stat_clr),
    .inc_i   (mismatch),
    .count_o (err_cnt)
  );

`ifdef COUNTER_MON_ERRLOG_EN
  logic [BIT_WIDTH-1:0] err_exp_log_q, err_obs_log_q;

  // The sticky flag doubles as "first mismatch already logged".
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_exp_log_q <= '0;
      err_obs_log_q <= '0;
    end else if (stat_clr) begin
      err_exp_log_q <= '0;
      err_obs_log_q <= '0;
    end else if (mismatch && !err_sticky_q) begin
      err_exp_log_q <= expected;
      err_obs_log_q <= cnt_val;
    end
  end

  assign err_exp_log = err_exp_log_q;
  assign err_obs_log = err_obs_log_q;
`endif

  assign locked     = (state_q == LOCKED);
  assign wrap_pulse = wrap_pulse_q;
  assign err_pulse  = err_pulse_q;
  assign err_sticky = err_sticky_q;

endmodule

// File: doc/counter_monitor.md
Name: counter_monitor

Overview:
- Passive receiving end of the counter interface: samples the counter's output value and enable every cycle and checks that the value follows the counting rule.
- Reports wrap events, mismatches, lock status and saturating statistics.
- Instanced alongside the counter in the top level on the same interface signals; drives nothing back into the counter.

Parameters:
- BIT_WIDTH, 5, width of the monitored count value
- STAT_WIDTH, 8, width of the wrap and error statistic counters
- RELOCK_CYCLES, 4, consecutive good comparisons needed to leave FAULT (must be >= 1)

Ports:
- clk  in  1  single clock; every register in the block is clocked by it
- rst_n  in  1  reset, synchronous, active-low
- cnt_en  in  1  counter enable as applied to the counter in this cycle
- cnt_val  in  BIT_WIDTH  counter output value in this cycle
- stat_clr  in  1  synchronous clear of statistics and sticky flag; returns to UNLOCKED
- locked  out  1  high in LOCKED state
- wrap_pulse  out  1  one-cycle pulse per observed wrap
- err_pulse  out  1  one-cycle pulse per observed mismatch
- err_sticky  out  1  set on any mismatch; cleared only by reset or stat_clr
- wrap_cnt  out  STAT_WIDTH  saturating count of wraps
- err_cnt  out  STAT_WIDTH  saturating count of mismatches

Behaviour:
- Reset (rst_n=0 at a clk edge): state=UNLOCKED; all outputs 0; prev_val=0, prev_en=0, good_run=0. Reset mid-operation discards all history.
- Every cycle: prev_val<=cnt_val, prev_en<=cnt_en.
- expected = prev_en ? (prev_val+1) mod 2^BIT_WIDTH : prev_val. Compare cnt_val against expected; no sign extension, arithmetic wraps at BIT_WIDTH bits.
- States:
  - UNLOCKED: no comparison. The first sampled cycle loads history. Next cycle -> LOCKED.
  - LOCKED: mismatch -> FAULT.
  - FAULT: each good comparison increments good_run; a mismatch resets good_run to 0. good_run==RELOCK_CYCLES -> LOCKED, good_run<=0.
- After a mismatch, history resyncs to the observed value. Subsequent checks are relative to it, so one glitch produces at most two mismatches: into and out of the glitch.
- Mismatch (compared in LOCKED or FAULT):
  - err_pulse=1 for exactly the next cycle
  - err_sticky<=1
  - err_cnt increments, saturating at all-ones
- Wrap: comparison good, prev_en=1, prev_val=all-ones, cnt_val=0.
  - wrap_pulse=1 next cycle
  - wrap_cnt increments, saturating
  - A mismatch is never also counted as a wrap.
- Output latency: registered, one cycle after the sample that caused them. locked reflects the current state register.
- stat_clr=1:
  - same cycle effect as reset on state, counters, sticky and pulses
  - history still captured from current inputs, so the monitor relocks after one cycle
  - if stat_clr coincides with a mismatch or wrap, the clear wins and no pulse is emitted.
- rst_n low has priority over stat_clr.
- cnt_en=0 for many cycles: value must hold; any change is a mismatch.

Optional Feature:
- Macro: COUNTER_MON_ERRLOG_EN.
- Defined:
  - adds outputs err_exp_log [BIT_WIDTH] and err_obs_log [BIT_WIDTH] holding expected/observed values of the FIRST mismatch since reset/stat_clr
  - frozen until cleared; reset value 0
- Undefined: ports and registers absent, all other behaviour identical.

Decomposition:
- Package counter_mon_pkg:
  - state enum mon_state_e {UNLOCKED, LOCKED, FAULT}
  - function next_expected(val, en)
- One natural sub-module: sat_counter (parameterised width, inc, clr, saturate at all-ones), instanced twice for wrap_cnt and err_cnt.

Test Plan (BIT_WIDTH=5, STAT_WIDTH=8, RELOCK_CYCLES=4):
1. Reset held 3 cycles, then cnt_en=1, cnt_val counting 0..31..0 -> locked=1 from cycle 2 on; one wrap_pulse after 31->0; wrap_cnt=1; err_cnt=0.
2. cnt_en=1, sequence 5,6,7,12,13,14,15,16 -> one err_pulse on 7->12; err_sticky=1; err_cnt=1; state FAULT; locked=1 again after 13..16 (four good compares).
3. cnt_en=0 holding 9, then cnt_val=10 for one cycle -> err_cnt=2 (into and out of glitch); no wrap_pulse.
4. Continuous mismatch for 300 cycles -> err_cnt saturates at 255; no rollover.
5. stat_clr pulsed in the same cycle as a 31->0 wrap -> no wrap_pulse; wrap_cnt=0; err_sticky=0; locked=0 for one cycle, then 1.
6. rst_n asserted mid-FAULT -> next cycle all outputs 0, state UNLOCKED; with COUNTER_MON_ERRLOG_EN, log registers 0, then first mismatch 7->12 logs exp=8, obs=12.
